// File: rtl/hex_disp_ctrl.sv
// Binary-to-seven-segment display controller: hex nibble split or double-dabble
// decimal conversion, leading-zero blanking, overflow dashes, registered segments.
module hex_disp_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_DIG = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_mode,
    input  logic                   i_blank_lz,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_ovf,
    output logic [7*NUM_DIG-1:0]   o_hex
);

    localparam int unsigned BCD_W = 4 * NUM_DIG;
    localparam int unsigned HEX_W = 7 * NUM_DIG;
    localparam int unsigned MAX_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HEXCONV  = 2'd1,
        DECSHIFT = 2'd2,
        UPDATE   = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  data_q;
    logic               blank_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept_c;
    logic               shift_done_c;
    logic [MAX_W-1:0]   data_ext_c;
    logic [BCD_W-1:0]   hex_digits_c;
    logic               hex_ovf_c;
    logic [BCD_W-1:0]   dd_adj_c;
    logic [BCD_W-1:0]   dd_bcd_c;
    logic               dd_out_c;
    logic [HEX_W-1:0]   seg_c;

    function automatic logic [6:0] seg_enc(input logic [3:0] n);
        case (n)
            4'h0: seg_enc = 7'h40;
            4'h1: seg_enc = 7'h79;
            4'h2: seg_enc = 7'h24;
            4'h3: seg_enc = 7'h30;
            4'h4: seg_enc = 7'h19;
            4'h5: seg_enc = 7'h12;
            4'h6: seg_enc = 7'h02;
            4'h7: seg_enc = 7'h78;
            4'h8: seg_enc = 7'h00;
            4'h9: seg_enc = 7'h10;
            4'hA: seg_enc = 7'h08;
            4'hB: seg_enc = 7'h03;
            4'hC: seg_enc = 7'h46;
            4'hD: seg_enc = 7'h21;
            4'hE: seg_enc = 7'h06;
            default: seg_enc = 7'h0E;
        endcase
    endfunction

    assign accept_c     = (state == IDLE) && i_start;
    assign shift_done_c = (cnt_q == CNT_W'(DATA_W));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; a settle cycle after the final shift gives DATA_W+2 decimal latency
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (i_start) state_nxt = i_mode ? DECSHIFT : HEXCONV;
            HEXCONV:  state_nxt = UPDATE;
            DECSHIFT: if (shift_done_c) state_nxt = UPDATE;
            UPDATE:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Hex digits: zero-extend short data, flag set bits beyond the display
    always_comb begin
        data_ext_c   = MAX_W'(data_q);
        hex_digits_c = data_ext_c[BCD_W-1:0];
        hex_ovf_c    = |(data_ext_c >> BCD_W);
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the data MSB
    always_comb begin
        dd_adj_c = bcd_q;
        for (int k = 0; k < int'(NUM_DIG); k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) dd_adj_c[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        dd_bcd_c = {dd_adj_c[BCD_W-2:0], data_q[DATA_W-1]};
        dd_out_c = dd_adj_c[BCD_W-1];
    end

    // Segment encoding with leading-zero blanking and overflow dashes
    always_comb begin
        logic       seen;
        logic [3:0] nib;
        seg_c = '0;
        seen  = 1'b0;
        nib   = '0;
        for (int k = int'(NUM_DIG) - 1; k >= 0; k--) begin
            nib = bcd_q[4*k +: 4];
            if (nib != 4'd0) seen = 1'b1;
            if (ovf_q)                              seg_c[7*k +: 7] = 7'h3F;
            else if (blank_q && !seen && (k != 0))  seg_c[7*k +: 7] = 7'h7F;
            else                                    seg_c[7*k +: 7] = seg_enc(nib);
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            blank_q <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_ovf   <= 1'b0;
            o_hex   <= {NUM_DIG{7'h7F}};
        end else begin
            o_busy <= (state_nxt != IDLE);
            o_done <= (state == UPDATE);
            if (accept_c) begin
                data_q  <= i_data;
                blank_q <= i_blank_lz;
                bcd_q   <= '0;
                ovf_q   <= 1'b0;
                cnt_q   <= '0;
            end
            if (state == HEXCONV) begin
                bcd_q <= hex_digits_c;
                ovf_q <= hex_ovf_c;
            end
            if ((state == DECSHIFT) && !shift_done_c) begin
                data_q <= data_q << 1;
                bcd_q  <= dd_bcd_c;
                ovf_q  <= ovf_q | dd_out_c;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (state == UPDATE) begin
                o_hex <= seg_c;
                o_ovf <= ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// Scoreboard bench for hex_disp_ctrl: stimulus pushes expected results, a monitor
// pops and compares on every o_done pulse, including the completion cycle.
module tb_hex_disp_ctrl;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_DIG = 8;
    localparam int unsigned HEX_W   = 7 * NUM_DIG;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [DATA_W-1:0]   i_data = '0;
    logic                i_mode = 1'b0;
    logic                i_blank_lz = 1'b0;
    logic                i_start = 1'b0;
    logic                o_busy;
    logic                o_done;
    logic                o_ovf;
    logic [HEX_W-1:0]    o_hex;

    hex_disp_ctrl #(.DATA_W(DATA_W), .NUM_DIG(NUM_DIG)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_data     (i_data),
        .i_mode     (i_mode),
        .i_blank_lz (i_blank_lz),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_ovf      (o_ovf),
        .o_hex      (o_hex)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HEX_W-1:0] hex;
        logic             ovf;
        int               due;
        string            name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [HEX_W-1:0] pack8(input logic [6:0] d7, input logic [6:0] d6,
                                               input logic [6:0] d5, input logic [6:0] d4,
                                               input logic [6:0] d3, input logic [6:0] d2,
                                               input logic [6:0] d1, input logic [6:0] d0);
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every o_done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && o_done === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got o_done=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_hex"}, 64'(o_hex), 64'(e.hex));
                check({e.name, "_ovf"}, 64'(o_ovf), 64'(e.ovf));
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic launch(input logic [DATA_W-1:0] data, input logic mode, input logic blank,
                          input logic [HEX_W-1:0] exp_hex, input logic exp_ovf,
                          input string name, input bit push);
        exp_t e;
        @(negedge clk);
        i_data = data; i_mode = mode; i_blank_lz = blank; i_start = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.hex = exp_hex; e.ovf = exp_ovf; e.name = name;
            e.due = cyc + (mode ? int'(DATA_W) + 2 : 2);
            q.push_back(e);
        end
        check({name, "_busy"}, 64'(o_busy), 64'(1));
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", name, q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] Z  = 7'h40;

    initial begin
        int a;
        #1 rst = 1'b1;
        #1;
        check("reset_hex",  64'(o_hex),  64'({NUM_DIG{7'h7F}}));
        check("reset_busy", 64'(o_busy), 64'(0));
        check("reset_done", 64'(o_done), 64'(0));
        check("reset_ovf",  64'(o_ovf),  64'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;

        launch(32'h0000_0002, 1'b0, 1'b1, pack8(BL,BL,BL,BL,BL,BL,BL,7'h24), 1'b0, "hex2_blank", 1'b1);
        wait_drain("hex2_blank");
        launch(32'h0000_0002, 1'b0, 1'b0, pack8(Z,Z,Z,Z,Z,Z,Z,7'h24), 1'b0, "hex2_noblank", 1'b1);
        wait_drain("hex2_noblank");
        launch(32'd123456, 1'b1, 1'b1, pack8(BL,BL,7'h79,7'h24,7'h30,7'h19,7'h12,7'h02), 1'b0,
               "dec123456", 1'b1);
        wait_drain("dec123456");
        launch(32'hFFFF_FFFF, 1'b1, 1'b1, {NUM_DIG{7'h3F}}, 1'b1, "dec_ovf", 1'b1);
        wait_drain("dec_ovf");
        launch(32'd0, 1'b1, 1'b1, pack8(BL,BL,BL,BL,BL,BL,BL,Z), 1'b0, "dec_zero", 1'b1);
        wait_drain("dec_zero");
        launch(32'hDEAD_BEEF, 1'b0, 1'b0, pack8(7'h21,7'h06,7'h08,7'h21,7'h03,7'h06,7'h06,7'h0E),
               1'b0, "hex_deadbeef", 1'b1);
        wait_drain("hex_deadbeef");
        launch(32'h00A0_0000, 1'b0, 1'b1, pack8(BL,BL,7'h08,Z,Z,Z,Z,Z), 1'b0, "hex_inner_zero", 1'b1);
        wait_drain("hex_inner_zero");
        launch(32'd99999999, 1'b1, 1'b0, {NUM_DIG{7'h10}}, 1'b0, "dec_max", 1'b1);
        wait_drain("dec_max");
        launch(32'd100000000, 1'b1, 1'b0, {NUM_DIG{7'h3F}}, 1'b1, "dec_ovf_edge", 1'b1);
        wait_drain("dec_ovf_edge");
        launch(32'd7, 1'b1, 1'b0, pack8(Z,Z,Z,Z,Z,Z,Z,7'h78), 1'b0, "dec7", 1'b1);
        wait_drain("dec7");

        // Restart attempt mid-conversion must be ignored and the old display held
        launch(32'd1000, 1'b1, 1'b1, pack8(BL,BL,BL,BL,7'h79,Z,Z,Z), 1'b0, "dec_ignore", 1'b1);
        repeat (4) @(negedge clk);
        i_data = 32'd42; i_mode = 1'b0; i_blank_lz = 1'b0; i_start = 1'b1;
        check("ignore_busy", 64'(o_busy), 64'(1));
        check("ignore_hold", 64'(o_hex), 64'(pack8(Z,Z,Z,Z,Z,Z,Z,7'h78)));
        @(negedge clk);
        i_start = 1'b0;
        wait_drain("dec_ignore");
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-conversion aborts it
        launch(32'd555, 1'b1, 1'b1, '0, 1'b0, "dec_abort", 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(o_busy), 64'(0));
        check("abort_done", 64'(o_done), 64'(0));
        check("abort_hex",  64'(o_hex),  64'({NUM_DIG{7'h7F}}));
        check("abort_ovf",  64'(o_ovf),  64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_hex_after", 64'(o_hex), 64'({NUM_DIG{7'h7F}}));
        launch(32'h5, 1'b0, 1'b1, pack8(BL,BL,BL,BL,BL,BL,BL,7'h12), 1'b0, "after_abort", 1'b1);
        wait_drain("after_abort");

        // Back-to-back hex conversions with i_start held high
        @(negedge clk);
        i_data = 32'h1; i_mode = 1'b0; i_blank_lz = 1'b1; i_start = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        for (int j = 0; j < 4; j++) begin
            exp_t e;
            e.hex = pack8(BL,BL,BL,BL,BL,BL,BL,7'h79); e.ovf = 1'b0;
            e.due = a + 3 * j + 2; e.name = $sformatf("b2b%0d", j);
            q.push_back(e);
        end
        while (cyc < a + 9) @(posedge clk);
        #1;
        i_start = 1'b0;
        check("b2b_busy4", 64'(o_busy), 64'(1));
        wait_drain("b2b");
        repeat (10) @(negedge clk);
        check("b2b_idle", 64'(o_busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000ns");
        $fatal(1);
    end

endmodule
